// File: rtl/clk_fwd_tx.sv
// clk_fwd_tx: generates a forwarded clock from clk and drives it off-chip through OBUFDS.
// Optional macro CLK_FWD_CNT_EN adds the completed-period counter output fwd_cnt.
module clk_fwd_tx #(
  parameter int DIV_A      = 2,
  parameter int DIV_B      = 5,
  parameter     IOSTANDARD = "DEFAULT",
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sel,
  output logic running,
  output logic sel_active,
  output logic clk_fwd_p,
  output logic clk_fwd_n
`ifdef CLK_FWD_CNT_EN
  ,
  output logic [CNT_W-1:0] fwd_cnt
`endif
);

  localparam int MAX_DIV = (DIV_A > DIV_B) ? DIV_A : DIV_B;
  localparam int HW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  if (DIV_A < 1 || DIV_B < 1) begin : g_bad_div
    $error("clk_fwd_tx: DIV_A and DIV_B must both be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("clk_fwd_tx: CNT_W must be >= 1");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          ph_q, ph_d;
  logic [HW-1:0] hc_q, hc_d;
  logic          cur_sel_q, cur_sel_d;
  logic [HW-1:0] half_m1;

  // en is a level request, not a handshake: it and sel are only looked at
  // when idle or at the end of a low half, so every period is always whole.
  assign half_m1 = cur_sel_q ? HW'(DIV_B - 1) : HW'(DIV_A - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ph_q      <= 1'b0;
      hc_q      <= '0;
      cur_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      hc_q      <= hc_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    hc_d      = hc_q;
    cur_sel_d = cur_sel_q;
    case (state_q)
      IDLE: begin
        ph_d = 1'b0;
        hc_d = '0;
        if (en) begin
          state_d   = RUN;
          cur_sel_d = sel;
          ph_d      = 1'b1;
        end
      end
      RUN: begin
        if (hc_q != half_m1) begin
          hc_d = hc_q + HW'(1);
        end else begin
          hc_d = '0;
          if (ph_q) begin
            ph_d = 1'b0;
          end else if (en) begin
            ph_d      = 1'b1;
            cur_sel_d = sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = 1'b0;
        hc_d    = '0;
      end
    endcase
  end

  assign running    = (state_q == RUN);
  assign sel_active = cur_sel_q;

`ifdef CLK_FWD_CNT_EN
  logic             period_end;
  logic [CNT_W-1:0] cnt_q;

  // Last cycle of a low half in RUN: the period boundary, whether or not we stop.
  assign period_end = (state_q == RUN) && !ph_q && (hc_q == half_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (period_end) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fwd_cnt = cnt_q;
`endif

  OBUFDS #(
    .IOSTANDARD(IOSTANDARD)
  ) u_obufds (
    .O (clk_fwd_p),
    .OB(clk_fwd_n),
    .I (ph_q)
  );

endmodule

// Behavioural stand-in for the vendor OBUFDS primitive; the vendor library
// model replaces it in implementation flows.
module OBUFDS #(
  parameter IOSTANDARD = "DEFAULT"
) (
  output logic O,
  output logic OB,
  input  logic I
);

  if ($bits(IOSTANDARD) < 8) begin : g_bad_std
    $error("OBUFDS: IOSTANDARD must be a non-empty string");
  end

  assign O  = I;
  assign OB = ~I;

endmodule
